// File: rtl/uart_ir_loader.sv
// uart_ir_loader: UART framed loader writing ram_ir; define LOADER_CSUM_EN to require a trailing XOR checksum byte
module uart_ir_loader #(
  parameter int CLK_HZ      = 60000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 6000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] ir_m_data,
  output logic [ADDR_W-1:0] ir_m_addr,
  output logic              ir_m_wren,
  output logic              loading,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words
);
  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE} st_t;
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  rx_st_t rs_q, rs_d;
  logic [31:0] rc_q, rc_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic byte_valid, frame_err;
  st_t st_q, st_d;
  logic [7:0] len_hi_q, len_hi_d, hi_q, hi_d;
  logic [15:0] rem_q, rem_d, n;
  logic [31:0] tmo_q, tmo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] words_q, words_d;
  logic wren_q, wren_d, loading_q, loading_d, done_q, done_d, err_q, err_d;
`ifdef LOADER_CSUM_EN
  localparam st_t LAST = CSUM;
  logic [7:0] csum_q, csum_d;
  // running XOR over length and data bytes, restarted whenever no frame is open
  always_comb csum_d = (st_q == IDLE) ? 8'd0 :
                       (byte_valid && st_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO}) ? csum_q ^ sh_q : csum_q;
  // checksum accumulator register
  always_ff @(posedge clock or posedge reset)
    if (reset) csum_q <= 8'd0;
    else csum_q <= csum_d;
`else
  localparam st_t LAST = DONE;
`endif
  assign n = {len_hi_q, sh_q};
  // 8N1 receiver: start re-checked at half bit, then data and stop sampled at bit centres
  always_comb begin
    rs_d = rs_q;
    rc_d = rc_q + 32'd1;
    bit_d = bit_q;
    sh_d = sh_q;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (rs_q)
      R_IDLE: begin
        rc_d = 32'd0;
        if (rx_s3_q && !rx_s2_q) rs_d = R_START;
      end
      R_START: if (rc_q == 32'(HALF - 1)) begin
        rc_d = 32'd0;
        bit_d = 3'd0;
        rs_d = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rc_q == 32'(CPB - 1)) begin
        rc_d = 32'd0;
        sh_d = {rx_s2_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) rs_d = R_STOP;
      end
      default: if (rc_q == 32'(CPB - 1)) begin
        rs_d = R_IDLE;
        byte_valid = rx_s2_q;
        frame_err = !rx_s2_q;
      end
    endcase
  end
  // frame decoder: sync, length, word pairs, optional checksum; aborts on framing error or timeout
  always_comb begin
    st_d = st_q;
    len_hi_d = len_hi_q;
    hi_d = hi_q;
    rem_d = rem_q;
    data_d = data_q;
    addr_d = addr_q;
    words_d = words_q;
    wren_d = 1'b0;
    loading_d = loading_q;
    done_d = 1'b0;
    err_d = err_q;
    tmo_d = (loading_q && !byte_valid) ? tmo_q + 32'd1 : 32'd0;
    case (st_q)
      IDLE: if (byte_valid && sh_q == 8'hA5) begin
        err_d = 1'b0;
        words_d = '0;
        loading_d = 1'b1;
        st_d = LEN_HI;
      end
      LEN_HI: if (byte_valid) begin
        len_hi_d = sh_q;
        st_d = LEN_LO;
      end
      LEN_LO: if (byte_valid) begin
        if (n == 16'd0 || {16'd0, n} > 32'(2 ** ADDR_W)) begin
          err_d = 1'b1;
          loading_d = 1'b0;
          st_d = IDLE;
        end else begin
          rem_d = n;
          st_d = DATA_HI;
        end
      end
      DATA_HI: if (byte_valid) begin
        hi_d = sh_q;
        st_d = DATA_LO;
      end
      DATA_LO: if (byte_valid) begin
        data_d = DATA_W'({hi_q, sh_q});
        addr_d = words_q[ADDR_W-1:0];
        wren_d = 1'b1;
        words_d = words_q + (ADDR_W + 1)'(1);
        rem_d = rem_q - 16'd1;
        st_d = (rem_q == 16'd1) ? LAST : DATA_HI;
      end
`ifdef LOADER_CSUM_EN
      CSUM: if (byte_valid) begin
        st_d = (sh_q == csum_q) ? DONE : IDLE;
        err_d = (sh_q != csum_q) | err_q;
        loading_d = (sh_q == csum_q);
      end
`endif
      DONE: begin
        done_d = 1'b1;
        loading_d = 1'b0;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (frame_err) begin
      err_d = 1'b1;
      if (st_q != IDLE) begin
        loading_d = 1'b0;
        st_d = IDLE;
      end
    end
    if (loading_q && tmo_q == 32'(TIMEOUT_CYC - 1)) begin
      err_d = 1'b1;
      loading_d = 1'b0;
      st_d = IDLE;
    end
  end
  // state registers; the rx synchroniser presets to the idle-high line level
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
      rs_q <= R_IDLE;
      rc_q <= 32'd0;
      bit_q <= 3'd0;
      sh_q <= 8'd0;
      st_q <= IDLE;
      len_hi_q <= 8'd0;
      hi_q <= 8'd0;
      rem_q <= 16'd0;
      tmo_q <= 32'd0;
      data_q <= '0;
      addr_q <= '0;
      words_q <= '0;
      wren_q <= 1'b0;
      loading_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      {rx_s1_q, rx_s2_q, rx_s3_q} <= {rx, rx_s1_q, rx_s2_q};
      rs_q <= rs_d;
      rc_q <= rc_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      st_q <= st_d;
      len_hi_q <= len_hi_d;
      hi_q <= hi_d;
      rem_q <= rem_d;
      tmo_q <= tmo_d;
      data_q <= data_d;
      addr_q <= addr_d;
      words_q <= words_d;
      wren_q <= wren_d;
      loading_q <= loading_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign ir_m_data = data_q;
  assign ir_m_addr = addr_q;
  assign ir_m_wren = wren_q;
  assign loading = loading_q;
  assign done = done_q;
  assign err = err_q;
  assign words = words_q;
endmodule

// File: tb/tb_uart_ir_loader.sv
// tb_uart_ir_loader: random and directed frames against a queued write/done scoreboard
module tb_uart_ir_loader;
  logic clock = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [15:0] ir_m_data;
  logic [11:0] ir_m_addr;
  logic ir_m_wren, loading, done, err;
  logic [12:0] words;
  int vec = 0, bad = 0, done_seen = 0, done_exp = 0;
  logic [27:0] exp_q[$];
  logic [15:0] fw[$];
  uart_ir_loader #(.CLK_HZ(1000000), .BAUD(100000), .ADDR_W(12), .DATA_W(16), .TIMEOUT_CYC(500)) dut (
    .clock(clock), .reset(reset), .rx(rx), .ir_m_data(ir_m_data), .ir_m_addr(ir_m_addr),
    .ir_m_wren(ir_m_wren), .loading(loading), .done(done), .err(err), .words(words));
  always #5 clock = ~clock;
  task automatic chk(input string nm, input int act, input int want);
    vec++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  // monitor: every write strobe must match the oldest expected write
  always @(negedge clock) begin : mon
    logic [27:0] e;
    if (ir_m_wren) begin
      chk("wren_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(ir_m_addr), int'(e[27:16]));
        chk("wr_data", int'(ir_m_data), int'(e[15:0]));
      end
    end
    if (done) done_seen++;
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (10) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clock);
    end
    rx = stop;
    repeat (10) @(negedge clock);
    rx = 1'b1;
  endtask
  task automatic gap();
    repeat ($urandom_range(0, 15)) @(negedge clock);
  endtask
  task automatic settle();
    repeat (8) @(negedge clock);
  endtask
  task automatic send_frame();
    logic [15:0] n;
    logic [7:0] cs;
    n = 16'(fw.size());
    cs = n[15:8] ^ n[7:0];
    send_byte(8'hA5, 1'b1);
    chk("loading_after_sync", int'(loading), 1);
    gap();
    send_byte(n[15:8], 1'b1);
    gap();
    send_byte(n[7:0], 1'b1);
    for (int i = 0; i < fw.size(); i++) begin
      gap();
      cs = cs ^ fw[i][15:8] ^ fw[i][7:0];
      send_byte(fw[i][15:8], 1'b1);
      gap();
      exp_q.push_back({12'(i), fw[i]});
      send_byte(fw[i][7:0], 1'b1);
    end
`ifdef LOADER_CSUM_EN
    gap();
    send_byte(cs, 1'b1);
`endif
    done_exp++;
    settle();
    chk("done_count", done_seen, done_exp);
    chk("words_frame", int'(words), fw.size());
    chk("err_frame", int'(err), 0);
    chk("loading_end", int'(loading), 0);
  endtask
  task automatic rand_frame();
    fw.delete();
    repeat ($urandom_range(1, 5)) fw.push_back(($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom));
    send_frame();
  endtask
  initial begin
    repeat (3) @(negedge clock);
    chk("rst_wren", int'(ir_m_wren), 0);
    chk("rst_loading", int'(loading), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_words", int'(words), 0);
    chk("rst_addr_data", int'({ir_m_addr, ir_m_data}), 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    send_byte(8'h11, 1'b1);
    settle();
    chk("junk_ignored", int'(loading), 0);
    fw = '{16'h1234, 16'hABCD};
    send_frame();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    settle();
    chk("len0_err", int'(err), 1);
    chk("len0_loading", int'(loading), 0);
    chk("len0_words", int'(words), 0);
    rand_frame();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h01, 1'b1);
    settle();
    chk("len4097_err", int'(err), 1);
    chk("len4097_loading", int'(loading), 0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 2; i++) begin
      send_byte(8'h5A, 1'b1);
      exp_q.push_back({12'(i), 8'h5A, 8'(i + 1)});
      send_byte(8'(i + 1), 1'b1);
    end
    repeat (470) @(negedge clock);
    chk("tmo_still_loading", int'(loading), 1);
    chk("tmo_err_before", int'(err), 0);
    repeat (50) @(negedge clock);
    chk("tmo_loading", int'(loading), 0);
    chk("tmo_err", int'(err), 1);
    chk("tmo_words", int'(words), 2);
    chk("tmo_no_done", done_seen, done_exp);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    settle();
    chk("ferr_err", int'(err), 1);
    chk("ferr_loading", int'(loading), 0);
    chk("ferr_words", int'(words), 0);
    rand_frame();
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    rand_frame();
`ifdef LOADER_CSUM_EN
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    exp_q.push_back({12'd0, 16'h0102});
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    settle();
    chk("csum_err", int'(err), 1);
    chk("csum_loading", int'(loading), 0);
    chk("csum_words", int'(words), 1);
    chk("csum_no_done", done_seen, done_exp);
`endif
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    exp_q.push_back({12'd0, 16'h1122});
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    rx = 1'b0;
    repeat (40) @(negedge clock);
    chk("pre_rst_loading", int'(loading), 1);
    chk("pre_rst_words", int'(words), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_loading", int'(loading), 0);
    chk("arst_words", int'(words), 0);
    chk("arst_outs", int'({ir_m_wren, done, err, ir_m_addr, ir_m_data}), 0);
    rx = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (120) @(negedge clock);
    chk("post_rst_loading", int'(loading), 0);
    rand_frame();
    for (int k = 0; k < 8; k++) rand_frame();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_total", done_seen, done_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
